// File: rtl/temp_uart_classifier_if.sv
// Port bundle for temp_uart_classifier: serial input, zone/temperature outputs and FSM debug taps.
// temp_valid and frame_err are single-cycle strobes with no ready. The consumer must sample on the cycle they are high.
interface temp_uart_classifier_if;
  logic       uart_rx;
  logic       temp_in_1;
  logic       temp_in_2;
  logic       temp_in_3;
  logic [7:0] temp_value;
  logic       temp_valid;
  logic       frame_err;
  logic [2:0] dbg_rx_state;
  logic [2:0] dbg_zone;

  modport master (
    input  uart_rx,
    output temp_in_1, temp_in_2, temp_in_3, temp_value, temp_valid, frame_err,
    output dbg_rx_state, dbg_zone
  );

  modport slave (
    output uart_rx,
    input  temp_in_1, temp_in_2, temp_in_3, temp_value, temp_valid, frame_err,
    input  dbg_rx_state, dbg_zone
  );
endinterface

// File: rtl/temp_uart_classifier.sv
// 8N1 UART receiver feeding a hysteretic three-zone temperature classifier.
// A stale-data timeout returns the zone to NONE.
module temp_uart_classifier #(
  parameter int CLKS_PER_BIT   = 5208,
  parameter int T_LOW          = 21,
  parameter int T_HIGH         = 23,
  parameter int HYST           = 1,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  temp_uart_classifier_if.master bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);
  localparam logic signed [8:0] LO   = 9'(T_LOW);
  localparam logic signed [8:0] HI   = 9'(T_HIGH);
  localparam logic signed [8:0] LO_H = 9'(T_LOW - HYST);
  localparam logic signed [8:0] HI_H = 9'(T_HIGH - HYST);

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  // One-hot encoding so the zone register bits are the output lines directly.
  typedef enum logic [2:0] {
    Z_NONE = 3'b000, Z_1 = 3'b001, Z_2 = 3'b010, Z_3 = 3'b100
  } zone_t;

  logic             rx_meta, rx_s;
  rx_state_t        rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok, byte_bad;

  zone_t            zone_q, zone_d, zone_cur;
  logic [TO_W-1:0]  to_q, to_d;
  logic             expired;
  logic [7:0]       value_q;
  logic             valid_q, ferr_q;
  logic signed [8:0] t_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_ok = 1'b1;
            rx_d    = RX_IDLE;
          end else begin
            byte_bad = 1'b1;
            rx_d     = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  assign expired = (to_q == TO_MAX);
  assign t_s     = $signed({1'b0, shift_q});

  // A byte arriving on the expiry cycle is classified as if the zone were already NONE.
  always_comb begin
    zone_cur = expired ? Z_NONE : zone_q;
    zone_d   = zone_cur;
    if (byte_ok) begin
      unique case (zone_cur)
        Z_NONE:  zone_d = (t_s < LO) ? Z_1 : (t_s > HI) ? Z_3 : Z_2;
        Z_1:     zone_d = (t_s > HI) ? Z_3 : (t_s >= LO) ? Z_2 : Z_1;
        Z_2:     zone_d = (t_s > HI) ? Z_3 : (t_s < LO_H) ? Z_1 : Z_2;
        Z_3:     zone_d = (t_s < LO_H) ? Z_1 : (t_s <= HI_H) ? Z_2 : Z_3;
        default: zone_d = Z_NONE;
      endcase
    end
    to_d = byte_ok ? '0 : (expired ? to_q : to_q + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q  <= Z_NONE;
      to_q    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      zone_q  <= zone_d;
      to_q    <= to_d;
      valid_q <= byte_ok;
      ferr_q  <= byte_bad;
      if (byte_ok) value_q <= shift_q;
    end
  end

  assign bus.temp_in_1    = zone_q[0];
  assign bus.temp_in_2    = zone_q[1];
  assign bus.temp_in_3    = zone_q[2];
  assign bus.temp_value   = value_q;
  assign bus.temp_valid   = valid_q;
  assign bus.frame_err    = ferr_q;
  assign bus.dbg_rx_state = rx_q;
  assign bus.dbg_zone     = zone_q;

endmodule
